// File: rtl/disp_sched.sv
// Round-robin owner of a shared D-digit hex display: each granted word is held for a minimum
// dwell before rotation, plus a free-running digit-scan strobe for the downstream mux.
module disp_sched #(
  parameter int N        = 2,
  parameter int D        = 4,
  parameter int TICK_DIV = 100000,
  parameter int DWELL    = 20,
  parameter int SCAN_DIV = 50000
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic [N-1:0]                      req_valid,
  input  logic [N-1:0][D-1:0][3:0]          req_data,
  output logic [N-1:0]                      req_ready,
  output logic [D-1:0][3:0]                 digits,
  output logic                              disp_on,
  output logic [$clog2(N > 1 ? N : 2)-1:0]  owner,
  output logic                              scan_tick
);

  localparam int OW = $clog2(N > 1 ? N : 2);
  localparam int PW = $clog2(TICK_DIV > 1 ? TICK_DIV : 2);
  localparam int DW = $clog2(DWELL + 1);
  localparam int SW = $clog2(SCAN_DIV > 1 ? SCAN_DIV : 2);

  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DWELL_END  = DW'(DWELL);
  localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SHOW = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  logic [1:0]    state_r;
  logic [1:0]    state_nx_s;
  logic [OW-1:0] last_owner_r;
  logic [OW-1:0] pick_idx_s;
  logic [OW-1:0] cand_s;
  logic [OW-1:0] take_idx_s;
  logic [N-1:0]  ready_s;
  logic          take_s;
  logic          restart_s;
  logic          any_s;
  logic          expired_s;
  logic [PW-1:0] presc_r;
  logic [DW-1:0] dwell_r;
  logic [SW-1:0] scan_cnt_r;

  assign any_s     = |req_valid;
  assign expired_s = (state_r == ST_SHOW) && (dwell_r == DWELL_END);
  assign req_ready = ready_s;

  // Round-robin search; descending loop so the nearest requester after last_owner wins.
  always_comb begin
    pick_idx_s = last_owner_r;
    cand_s     = last_owner_r;
    for (int k = N; k >= 1; k--) begin
      cand_s = OW'((int'(last_owner_r) + k) % N);
      if (req_valid[cand_s]) begin
        pick_idx_s = cand_s;
      end else begin
        pick_idx_s = pick_idx_s;
      end
    end
  end

  // Grant decision and next state; at most one transfer per cycle.
  always_comb begin
    ready_s    = '0;
    take_s     = 1'b0;
    take_idx_s = pick_idx_s;
    restart_s  = 1'b0;
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE, ST_HOLD: begin
        if (any_s) begin
          take_s     = 1'b1;
          restart_s  = 1'b1;
          state_nx_s = ST_SHOW;
        end else begin
          state_nx_s = state_r;
        end
      end
      ST_SHOW: begin
        if (expired_s) begin
          if (any_s) begin
            take_s    = 1'b1;
            restart_s = 1'b1;
          end else begin
            state_nx_s = ST_HOLD;
          end
        end else if (req_valid[owner]) begin
          take_s     = 1'b1;
          take_idx_s = owner;
        end else begin
          take_s = 1'b0;
        end
      end
      default: state_nx_s = ST_IDLE;
    endcase
    if (take_s) begin
      ready_s[take_idx_s] = 1'b1;
    end else begin
      ready_s = '0;
    end
  end

  // Display word, owner and round-robin pointer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= ST_IDLE;
      digits       <= '0;
      disp_on      <= 1'b0;
      owner        <= '0;
      last_owner_r <= OW'(N - 1);
    end else begin
      state_r <= state_nx_s;
      if (take_s) begin
        digits       <= req_data[take_idx_s];
        disp_on      <= 1'b1;
        owner        <= take_idx_s;
        last_owner_r <= take_idx_s;
      end
    end
  end

  // Dwell timing: both counters freeze once the dwell is spent, so neither can overflow.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc_r <= '0;
      dwell_r <= '0;
    end else if (restart_s) begin
      presc_r <= '0;
      dwell_r <= '0;
    end else if ((state_r == ST_SHOW) && !expired_s) begin
      if (presc_r == PRESC_LAST) begin
        presc_r <= '0;
        dwell_r <= dwell_r + {{(DW-1){1'b0}}, 1'b1};
      end else begin
        presc_r <= presc_r + {{(PW-1){1'b0}}, 1'b1};
      end
    end
  end

  // Free-running scan strobe, registered on the wrap to zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      scan_cnt_r <= '0;
      scan_tick  <= 1'b0;
    end else begin
      scan_tick <= (scan_cnt_r == SCAN_LAST);
      if (scan_cnt_r == SCAN_LAST) begin
        scan_cnt_r <= '0;
      end else begin
        scan_cnt_r <= scan_cnt_r + {{(SW-1){1'b0}}, 1'b1};
      end
    end
  end

endmodule

// File: tb/tb_disp_sched.sv
// Randomized scoreboard bench for disp_sched against a time-stamp based reference model.
module tb_disp_sched;
  localparam int N = 2, D = 4, TICK_DIV = 4, DWELL = 3, SCAN_DIV = 5;
  localparam int S_IDLE = 0, S_SHOW = 1, S_HOLD = 2;

  logic                     clk = 1'b0;
  logic                     reset_n;
  logic [N-1:0]             req_valid;
  logic [N-1:0][D-1:0][3:0] req_data;
  logic [N-1:0]             req_ready;
  logic [D-1:0][3:0]        digits;
  logic                     disp_on;
  logic [0:0]               owner;
  logic                     scan_tick;

  disp_sched #(.N(N), .D(D), .TICK_DIV(TICK_DIV), .DWELL(DWELL), .SCAN_DIV(SCAN_DIV)) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .digits(digits), .disp_on(disp_on), .owner(owner),
    .scan_tick(scan_tick)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] dig;
    int          own;
    logic        on;
    logic        scan;
  } disp_t;

  logic [N-1:0] rdy_q[$];
  disp_t        disp_q[$];

  int tests = 0;
  int fails = 0;

  // reference model: spec-level state plus edge time stamps
  int          m_state, m_owner, m_last, now, grant_edge;
  logic [15:0] m_dig;
  logic        m_on;
  logic        pend[N];
  logic [15:0] pdata[N];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int rr_pick();
    for (int k = 1; k <= N; k++) begin
      if (pend[(m_last + k) % N]) return (m_last + k) % N;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_state = S_IDLE; m_owner = 0; m_last = N - 1; now = 0; grant_edge = 0;
    m_dig = 16'h0000; m_on = 1'b0;
  endtask

  task automatic step_body();
    int    win;
    bit    expired;
    disp_t d;
    for (int i = 0; i < N; i++) begin
      req_valid[i] = pend[i];
      req_data[i]  = pdata[i];
    end
    #1;
    expired = (m_state == S_SHOW) && ((now - grant_edge) >= DWELL * TICK_DIV);
    case (m_state)
      S_IDLE, S_HOLD: win = rr_pick();
      S_SHOW:         win = expired ? rr_pick() : (pend[m_owner] ? m_owner : -1);
      default:        win = -1;
    endcase
    rdy_q.push_back((win >= 0) ? (N'(1) << win) : N'(0));
    if (win >= 0) begin
      if (!(m_state == S_SHOW && !expired)) grant_edge = now + 1;
      m_dig = pdata[win]; m_owner = win; m_last = win; m_on = 1'b1;
      m_state = S_SHOW; pend[win] = 1'b0;
    end else if (expired) begin
      m_state = S_HOLD;
    end
    now++;
    d.dig = m_dig; d.own = m_owner; d.on = m_on; d.scan = ((now % SCAN_DIV) == 0);
    disp_q.push_back(d);
  endtask

  task automatic step(input int n);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      step_body();
    end
  endtask

  task automatic offer(input int i, input logic [15:0] data);
    pend[i] = 1'b1;
    pdata[i] = data;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("rst_digits", digits, 32'h0);
    check("rst_disp_on", disp_on, 32'h0);
    check("rst_owner", owner, 32'h0);
    check("rst_req_ready", req_ready, 32'h0);
    check("rst_scan_tick", scan_tick, 32'h0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    step_body();
  endtask

  task automatic rand_req();
    for (int i = 0; i < N; i++) begin
      if (!pend[i] && $urandom_range(0, 5) == 0) offer(i, 16'($urandom));
      else if (pend[i] && $urandom_range(0, 24) == 0) pend[i] = 1'b0;
    end
  endtask

  // ready monitor: the Mealy response of the cycle
  initial begin
    logic [N-1:0] e;
    forever begin
      @(negedge clk);
      #2;
      if (rdy_q.size() > 0) begin
        e = rdy_q.pop_front();
        check("req_ready", req_ready, e);
      end
    end
  end

  // display monitor: registered outputs after the edge
  initial begin
    disp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (disp_q.size() > 0) begin
        e = disp_q.pop_front();
        check("digits", digits, e.dig);
        check("owner", owner, e.own);
        check("disp_on", disp_on, e.on);
        check("scan_tick", scan_tick, e.scan);
      end
    end
  end

  initial begin
    reset_n   = 1'b0;
    req_valid = '0;
    req_data  = '0;
    for (int i = 0; i < N; i++) begin pend[i] = 1'b0; pdata[i] = 16'h0; end
    model_reset();
    do_reset();
    step(16);                         // idle: blank display, scan ticks at 5,10,15
    offer(0, 16'h1234);
    offer(1, 16'hABCD);
    step(16);                         // req0 first, req1 after 12-clock dwell
    step(16);                         // req1 dwell expires with no request -> HOLD
    offer(0, 16'h5555);
    step(5);                          // grant from HOLD
    offer(0, 16'h0042);
    offer(1, 16'hC0DE);
    step(12);                         // owner update mid-dwell, rotation to 1 on schedule
    step(3);
    offer(0, 16'h7777);
    offer(1, 16'h8888);
    do_reset();                       // reset mid-SHOW, then both valid -> 0 first
    step(20);
    for (int c = 0; c < 1500; c++) begin
      rand_req();
      step(1);
      if (c == 700) do_reset();
    end
    for (int i = 0; i < N; i++) pend[i] = 1'b0;
    step(4);
    @(negedge clk);
    @(negedge clk);
    check("queues_drained", rdy_q.size() + disp_q.size(), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
